// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes (also used by ALU control), FSM states and width defaults.
package alu_pkg;

  localparam int ALU_DATA_WIDTH  = 32;
  localparam int ALU_SHAMT_WIDTH = 5;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_LUI = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-clock shifter: load acc/cnt/direction, then shift once per edge until cnt hits 0.
module alu_serial_shifter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic                   dir_left_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  result_o
);

  logic [DATA_WIDTH-1:0]  acc_reg;
  logic [DATA_WIDTH-1:0]  acc_next;
  logic [SHAMT_WIDTH-1:0] cnt_reg;
  logic                   dir_left_reg;

  assign acc_next = dir_left_reg ? {acc_reg[DATA_WIDTH-2:0], 1'b0}
                                 : {1'b0, acc_reg[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg      <= '0;
      cnt_reg      <= '0;
      dir_left_reg <= 1'b0;
    end else if (load_i) begin
      acc_reg      <= a_i;
      cnt_reg      <= shamt_i;
      dir_left_reg <= dir_left_i;
    end else if (cnt_reg != '0) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg - SHAMT_WIDTH'(1);
    end
  end

  // done marks the edge on which cnt goes 1->0; result_o is the value acc takes on that edge
  assign done_o   = (cnt_reg == SHAMT_WIDTH'(1));
  assign result_o = acc_next;

endmodule

// File: rtl/alu_multicycle_exec.sv
// Multicycle ALU execute stage with start/ready/valid handshake; shifts are serial unless
// ALU_BARREL_SHIFT_EN is defined, which swaps in a single-cycle barrel shifter.
module alu_multicycle_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
  parameter int SHAMT_WIDTH = ALU_SHAMT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o
);

  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  single_result;
  logic                   accept;
  logic                   valid_reg;
  logic                   zero_reg;
  logic [DATA_WIDTH-1:0]  result_reg;

  assign shamt  = B_i[SHAMT_WIDTH-1:0];
  assign accept = start_i && ready_o;

  always_comb begin
    single_result = '0;
    case (ALU_Operation_i)
      ALU_ADD: single_result = A_i + B_i;
      ALU_SUB: single_result = A_i - B_i;
      ALU_AND: single_result = A_i & B_i;
      ALU_OR:  single_result = A_i | B_i;
      ALU_XOR: single_result = A_i ^ B_i;
      ALU_LUI: single_result = B_i;
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SRL: single_result = A_i >> shamt;
      ALU_SLL: single_result = A_i << shamt;
`else
      // only reached with shamt==0; non-zero amounts go through the serial shifter
      ALU_SRL: single_result = A_i;
      ALU_SLL: single_result = A_i;
`endif
      default: single_result = '0;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN

  assign ready_o = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg  <= 1'b0;
      result_reg <= '0;
      zero_reg   <= 1'b1;
    end else begin
      valid_reg <= 1'b0;
      if (accept) begin
        result_reg <= single_result;
        zero_reg   <= (single_result == '0);
        valid_reg  <= 1'b1;
      end
    end
  end

`else

  state_t                state_reg;
  logic                  ready_reg;
  logic                  is_shift;
  logic                  shift_load;
  logic                  shift_done;
  logic [DATA_WIDTH-1:0] shift_result;

  assign is_shift   = (ALU_Operation_i == ALU_SRL) || (ALU_Operation_i == ALU_SLL);
  assign shift_load = accept && is_shift && (shamt != '0);
  assign ready_o    = ready_reg;

  alu_serial_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (shift_load),
    .dir_left_i (ALU_Operation_i == ALU_SLL),
    .a_i        (A_i),
    .shamt_i    (shamt),
    .done_o     (shift_done),
    .result_o   (shift_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      ready_reg  <= 1'b1;
      valid_reg  <= 1'b0;
      result_reg <= '0;
      zero_reg   <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          valid_reg <= 1'b0;
          if (shift_load) begin
            state_reg <= ST_SHIFT;
            ready_reg <= 1'b0;
          end else if (accept) begin
            result_reg <= single_result;
            zero_reg   <= (single_result == '0);
            valid_reg  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          valid_reg <= 1'b0;
          if (shift_done) begin
            result_reg <= shift_result;
            zero_reg   <= (shift_result == '0);
            valid_reg  <= 1'b1;
            ready_reg  <= 1'b1;
            state_reg  <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

`endif

  assign valid_o      = valid_reg;
  assign ALU_Result_o = result_reg;
  assign Zero_o       = zero_reg;

endmodule

// File: tb/tb_alu_multicycle_exec.sv
// Bench for alu_multicycle_exec: latency/result model plus directed literal checks and random traffic.
module tb_alu_multicycle_exec;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  ALU_Operation_i = 4'd0;
  logic [31:0] A_i = 32'd0;
  logic [31:0] B_i = 32'd0;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] ALU_Result_o;
  logic        Zero_o;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  alu_multicycle_exec dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .ALU_Operation_i (ALU_Operation_i),
    .A_i             (A_i),
    .B_i             (B_i),
    .ready_o         (ready_o),
    .valid_o         (valid_o),
    .ALU_Result_o    (ALU_Result_o),
    .Zero_o          (Zero_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return b;
      4'd6: return a >> b[4:0];
      4'd7: return a << b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Model: an accepted op finishes after (shift ? shamt : 0) extra edges; busy blocks accepts.
  int          m_busy = 0;
  logic [31:0] m_pending = 32'd0;
  logic        m_ready = 1'b1;
  logic        m_valid = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic        m_zero = 1'b1;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_busy = 0; m_ready = 1'b1; m_valid = 1'b0; m_result = 32'd0; m_zero = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_result = m_pending; m_zero = (m_pending == 32'd0);
          m_valid = 1'b1; m_ready = 1'b1;
        end
      end else if (start_i && m_ready) begin
        int lat;
        lat = (!BARREL && (ALU_Operation_i == 4'd6 || ALU_Operation_i == 4'd7)) ? int'(B_i[4:0]) : 0;
        if (lat == 0) begin
          m_result = ref_alu(ALU_Operation_i, A_i, B_i);
          m_zero = (m_result == 32'd0);
          m_valid = 1'b1;
        end else begin
          m_pending = ref_alu(ALU_Operation_i, A_i, B_i);
          m_busy = lat;
          m_ready = 1'b0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      checks++;
      if (ready_o !== m_ready || valid_o !== m_valid || ALU_Result_o !== m_result || Zero_o !== m_zero) begin
        errors++;
        $display("FAIL model t=%0t: got rdy=%b vld=%b res=%h z=%b, expected rdy=%b vld=%b res=%h z=%b",
                 $time, ready_o, valid_o, ALU_Result_o, Zero_o, m_ready, m_valid, m_result, m_zero);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1; ALU_Operation_i = op; A_i = a; B_i = b;
  endtask

  // From just after the accept edge, count further edges until valid_o (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_o && n < 40) begin
      @(posedge clk); #1; n++;
    end
  endtask

  int n;
  int vcount;

  initial begin
    #2 reset = 1'b0;
    checking = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready_o}, 32'd1);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_result", ALU_Result_o, 32'd0);
    check("reset_zero", {31'd0, Zero_o}, 32'd1);

    // Back-to-back ADD then SUB
    drive(4'b0000, 32'h5, 32'h3);
    @(posedge clk); #1;
    check("add_valid", {31'd0, valid_o}, 32'd1);
    check("add_result", ALU_Result_o, 32'h8);
    check("add_zero", {31'd0, Zero_o}, 32'd0);
    drive(4'b0001, 32'h5, 32'h5);
    @(posedge clk); #1;
    start_i = 1'b0;
    check("sub_valid", {31'd0, valid_o}, 32'd1);
    check("sub_result", ALU_Result_o, 32'h0);
    check("sub_zero", {31'd0, Zero_o}, 32'd1);
    @(posedge clk); #1;
    check("valid_drop", {31'd0, valid_o}, 32'd0);

    // SLL by 31 with start held; extra requests must be ignored
    drive(4'b0111, 32'h1, 32'h1F);
    @(posedge clk); #1;
    A_i = $urandom; B_i = $urandom; ALU_Operation_i = 4'($urandom_range(0, 15));
    check("sll31_ready_low", {31'd0, ready_o}, BARREL ? 32'd1 : 32'd0);
    wait_valid(n);
    start_i = 1'b0;
    check("sll31_latency", n, BARREL ? 32'd0 : 32'd31);
    check("sll31_result", ALU_Result_o, 32'h80000000);
    @(posedge clk); #1;

    drive(4'b0110, 32'h80000000, 32'h4);
    @(posedge clk); #1; start_i = 1'b0;
    wait_valid(n);
    check("srl4_latency", n, BARREL ? 32'd0 : 32'd4);
    check("srl4_result", ALU_Result_o, 32'h08000000);

    drive(4'b0110, 32'h80000000, 32'h20);
    @(posedge clk); #1; start_i = 1'b0;
    wait_valid(n);
    check("srl0_latency", n, 32'd0);
    check("srl0_result", ALU_Result_o, 32'h80000000);

    drive(4'b0101, 32'hDEADBEEF, 32'h12345000);
    @(posedge clk); #1;
    check("lui_result", ALU_Result_o, 32'h12345000);
    drive(4'b1010, 32'hFFFFFFFF, 32'h1);
    @(posedge clk); #1; start_i = 1'b0;
    check("undef_result", ALU_Result_o, 32'h0);
    check("undef_zero", {31'd0, Zero_o}, 32'd1);

    // Reset mid-SLL by 10
    drive(4'b0111, 32'h3, 32'd10);
    @(posedge clk); #1; start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready_o}, 32'd1);
    check("midrst_valid", {31'd0, valid_o}, 32'd0);
    check("midrst_result", ALU_Result_o, 32'd0);
    check("midrst_zero", {31'd0, Zero_o}, 32'd1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    vcount = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (valid_o) vcount++;
    end
    check("midrst_no_valid", vcount, 32'd0);

    // Random traffic, checked every cycle by the model
    repeat (2500) begin
      start_i = ($urandom_range(0, 2) != 0);
      ALU_Operation_i = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 7)) : 4'($urandom_range(0, 15));
      A_i = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      B_i = $urandom;
      if ($urandom_range(0, 1) == 1) B_i[4:0] = 5'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    n = 0;
    while (!ready_o && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("final_idle", {31'd0, ready_o}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_multicycle_exec.md
Name: alu_multicycle_exec

Overview:
- Execution end of the ALU operation interface: consumes the 4-bit ALU operation code produced by ALU control, plus two operands.
- Produces a registered result with a start/ready/valid handshake.
- Logic ops and add/sub complete in one cycle; shifts iterate one bit per clock, bounding shifter area.
- Sits between the register-file/immediate muxes and the write-back path of the multicycle datapath variant.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- SHAMT_WIDTH, 5, shift-amount bits taken from B_i[SHAMT_WIDTH-1:0]; must equal log2(DATA_WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  request; accepted on a rising edge where start_i=1 and ready_o=1.
- ALU_Operation_i  input  4  operation code, sampled at accept.
- A_i  input  DATA_WIDTH  operand A, sampled at accept.
- B_i  input  DATA_WIDTH  operand B / shift amount, sampled at accept.
- ready_o  output  1  high when a new request can be accepted.
- valid_o  output  1  one-cycle pulse; ALU_Result_o and Zero_o are new.
- ALU_Result_o  output  DATA_WIDTH  registered result, held until the next completion.
- Zero_o  output  1  registered (ALU_Result_o == 0), updated together with the result.

Behaviour:
- Reset (asserted, async):
  - state=IDLE, ready_o=1, valid_o=0, ALU_Result_o=0, Zero_o=1, shift counter=0, accumulator=0.
- Op codes (sampled at accept):
  - 0000 ADD A+B; 0001 SUB A-B; 0010 AND; 0011 OR; 0100 XOR.
  - 0101 LUI: result=B.
  - 0110 SRL logical right by B[4:0]; 0111 SLL left by B[4:0].
  - 1000-1111 undefined: result=0, single-cycle path.
- Arithmetic: modulo 2^DATA_WIDTH, carry/overflow discarded.
- FSM states: IDLE, SHIFT.
  - IDLE, accept, non-shift op: result/Zero registered at the accept edge E0; valid_o=1 for the cycle after E0; stay IDLE, ready_o stays 1. Back-to-back accepts give one result per cycle.
  - IDLE, accept, shift with shamt=0: same as non-shift; result=A.
  - IDLE, accept, shift with shamt=k>0: at E0 load acc=A, cnt=k, direction bit; go to SHIFT; ready_o=0, valid_o=0.
  - SHIFT: each edge shifts acc by 1 (zero-fill) and decrements cnt. On the edge where cnt goes 1->0, register the result, set valid_o=1 and ready_o=1, return to IDLE. Total: k edges after E0.
- ready_o=0 only in SHIFT. start_i while ready_o=0 is ignored; no queueing.
- ALU_Operation_i, A_i and B_i are don't-care except at accept.
- valid_o deasserts the cycle after its pulse unless a new single-cycle completion occurs.
- Reset during SHIFT aborts the operation; all outputs take reset values. No stale valid_o after release.
- Maximum latency: 31 cycles (shamt=31).

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: SRL/SLL use a combinational barrel shifter and complete in one cycle like other ops. SHIFT state and counter are not built; ready_o is tied to 1 after reset.
- Undefined: iterative behaviour above.
- Results are identical in both builds; only latency differs.

Decomposition:
- Shared package alu_pkg:
  - 4-bit op-code localparams (ALU_ADD..ALU_SLL); ALU control imports the same values.
  - FSM state encoding.
  - DATA_WIDTH/SHAMT_WIDTH defaults.
- One natural sub-module: alu_serial_shifter (acc, cnt, dir, done), excluded under ALU_BARREL_SHIFT_EN.
- Single-cycle ops stay inline.

Test Plan:
- Reset released, no start -> ready_o=1, valid_o=0, ALU_Result_o=0, Zero_o=1.
- Back-to-back ADD A=0x00000005 B=0x00000003, then SUB A=5 B=5 -> valid pulses on consecutive cycles; results 0x00000008 (Zero_o=0) then 0x00000000 (Zero_o=1).
- SLL A=0x00000001 B=0x0000001F, start held high throughout -> ready_o low 31 cycles; extra starts ignored; valid after 31 cycles with 0x80000000.
- SRL A=0x80000000 B=4 -> valid 4 cycles after accept, 0x08000000. SRL with B=0x20 (shamt 0) -> 1-cycle, result 0x80000000.
- LUI B=0x12345000 -> 0x12345000. Op 1010 -> 0x00000000, Zero_o=1.
- Reset asserted mid-SLL (cycle 3 of 10) -> outputs to reset values asynchronously; after release ready_o=1, no valid pulse.
